// File: rtl/buart_pkg.sv
// buart_pkg: shared constants and types for the buart serial port.
//   FRAME_BITS / DATA_BITS : 8N1 frame geometry
//   START_BIT / STOP_BIT   : line levels of the framing bits
//   ACC_W                  : width of the signed tick accumulator
//   rx_state_t             : receiver FSM states
package buart_pkg;
    localparam int   FRAME_BITS = 10;
    localparam int   DATA_BITS  = 8;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    // Holds rate - CLKFREQ down to -(2^31) and sums up to 2*(2^31) without overflow.
    localparam int   ACC_W      = 34;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
endpackage

// File: rtl/buart_baudgen.sv
// buart_baudgen: fractional tick generator. Emits a one-cycle ser_clk pulse at
// a mean rate of `baud` ticks per second, with +-1 cycle jitter.
// Ports:
//   clk      in   clock
//   resetq   in   synchronous active-low reset (loads as restart)
//   baud[31:0] in tick rate in Hz, sampled every cycle
//   restart  in   realign: first tick comes one full period later
//   ser_clk  out  tick pulse
module buart_baudgen
    import buart_pkg::*;
#(
    parameter int CLKFREQ = 100_000_000
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic [31:0] baud,
    input  logic        restart,
    output logic        ser_clk
);
    localparam logic signed [ACC_W-1:0] FREQ = ACC_W'(CLKFREQ);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] rate;

    assign rate    = $signed({{(ACC_W-32){1'b0}}, baud});
    assign ser_clk = ~acc[ACC_W-1];

    always_ff @(posedge clk) begin
        if (!resetq || restart)
            acc <= rate - FREQ;
        else if (ser_clk)
            acc <= acc + rate - FREQ;
        else
            acc <= acc + rate;
    end
endmodule

// File: rtl/buart_core.sv
// buart_core: 8N1 UART (one receiver, one transmitter) with runtime baud rate.
// Ports:
//   clk, resetq       clock, synchronous active-low reset
//   baud[31:0]        bit rate in bit/s (0 < 2*baud < CLKFREQ)
//   rx                serial input (asynchronous, idle high)
//   rd                acknowledge received byte (clears valid)
//   wr, tx_data[7:0]  start transmitting tx_data when not busy
//   tx                serial output (idle high)
//   valid             unread byte in rx_data
//   busy              transmitter sending a frame
//   rx_data[7:0]      last received byte
// Build option: BUART_FRAMING_CHECK_EN discards bytes whose stop bit reads 0.
module buart_core
    import buart_pkg::*;
#(
    parameter int CLKFREQ = 100_000_000
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic [31:0] baud,
    input  logic        rx,
    input  logic        rd,
    input  logic        wr,
    input  logic [7:0]  tx_data,
    output logic        tx,
    output logic        valid,
    output logic        busy,
    output logic [7:0]  rx_data
);
    // ---------------- receiver ----------------
    logic       rx_m, rx_s, rx_q;   // two sync flops plus one for edge detect
    rx_state_t  rx_state;
    logic       rx_tick, rx_restart, rx_half;
    logic [2:0] rx_cnt;
    logic [7:0] rx_shift;

    always_ff @(posedge clk) begin
        if (!resetq) {rx_m, rx_s, rx_q} <= 3'b111;
        else         {rx_m, rx_s, rx_q} <= {rx, rx_m, rx_s};
    end

    // A falling edge in IDLE realigns the half-bit ticks to the start edge.
    // Requiring an edge (not a low level) also keeps the receiver disarmed
    // after a bad stop bit until the line has returned high.
    assign rx_restart = (rx_state == IDLE) && rx_q && !rx_s;

    buart_baudgen #(.CLKFREQ(CLKFREQ)) u_rx_gen (
        .clk     (clk),
        .resetq  (resetq),
        .baud    ({baud[30:0], 1'b0}),
        .restart (rx_restart),
        .ser_clk (rx_tick)
    );

    always_ff @(posedge clk) begin
        if (!resetq) begin
            rx_state <= IDLE;
            rx_half  <= 1'b0;
            rx_cnt   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            valid    <= 1'b0;
        end else begin
            // A byte load later in this block overrides the rd clear.
            if (rd) valid <= 1'b0;
            case (rx_state)
                IDLE: if (rx_restart) rx_state <= START;
                START: if (rx_tick) begin
                    if (rx_s != START_BIT) begin
                        rx_state <= IDLE;
                    end else begin
                        rx_state <= DATA;
                        rx_half  <= 1'b0;
                        rx_cnt   <= '0;
                    end
                end
                // Ticks alternate bit edge / bit centre; sample on the centre.
                DATA: if (rx_tick) begin
                    rx_half <= ~rx_half;
                    if (rx_half) begin
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        rx_cnt   <= rx_cnt + 3'd1;
                        if (rx_cnt == 3'(DATA_BITS-1)) rx_state <= STOP;
                    end
                end
                STOP: if (rx_tick) begin
                    rx_half <= ~rx_half;
                    if (rx_half) begin
                        rx_state <= IDLE;
`ifdef BUART_FRAMING_CHECK_EN
                        if (rx_s == STOP_BIT) begin
                            rx_data <= rx_shift;
                            valid   <= 1'b1;
                        end
`else
                        rx_data <= rx_shift;
                        valid   <= 1'b1;
`endif
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    // ---------------- transmitter ----------------
    logic       tx_tick, tx_start;
    logic [9:0] tx_shift;   // tx is bit 0 of the shifter
    logic [3:0] tx_cnt;     // bits already completed

    assign tx_start = wr && !busy;
    assign tx       = tx_shift[0];

    buart_baudgen #(.CLKFREQ(CLKFREQ)) u_tx_gen (
        .clk     (clk),
        .resetq  (resetq),
        .baud    (baud),
        .restart (tx_start),
        .ser_clk (tx_tick)
    );

    always_ff @(posedge clk) begin
        if (!resetq) begin
            tx_shift <= '1;
            tx_cnt   <= '0;
            busy     <= 1'b0;
        end else if (tx_start) begin
            tx_shift <= {STOP_BIT, tx_data, START_BIT};
            tx_cnt   <= '0;
            busy     <= 1'b1;
        end else if (busy && tx_tick) begin
            // Last tick ends the stop bit; the line is already high.
            if (tx_cnt == 4'(FRAME_BITS-1)) begin
                busy <= 1'b0;
            end else begin
                tx_shift <= {1'b1, tx_shift[9:1]};
                tx_cnt   <= tx_cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_buart_core.sv
module tb_buart_core;
    localparam int CLKF = 100_000_000;
    localparam int SLOW = 115_200;
    localparam int FAST = 1_152_000;

`ifdef BUART_FRAMING_CHECK_EN
    localparam logic       FR_V = 1'b0;
    localparam logic [7:0] FR_D = 8'h00;
`else
    localparam logic       FR_V = 1'b1;
    localparam logic [7:0] FR_D = 8'hFF;
`endif

    logic        clk = 1'b0;
    logic        resetq, rx, rd, wr, tx, valid, busy;
    logic [31:0] baud;
    logic [7:0]  tx_data, rx_data;
    logic        g_resetq, g_restart, g_tick;

    int n_err = 0;
    int n_chk = 0;
    bit tick_done = 1'b0;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       rd;
        logic       exp_v;
        logic [7:0] exp_d;
    } rxv_t;
    rxv_t tbl [7];

    always #5 clk = ~clk;

    buart_core #(.CLKFREQ(CLKF)) dut (
        .clk(clk), .resetq(resetq), .baud(baud), .rx(rx), .rd(rd), .wr(wr),
        .tx_data(tx_data), .tx(tx), .valid(valid), .busy(busy), .rx_data(rx_data)
    );

    buart_baudgen #(.CLKFREQ(CLKF)) gen (
        .clk(clk), .resetq(g_resetq), .baud(32'(SLOW)), .restart(g_restart), .ser_clk(g_tick)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic wait_cyc(input longint n);
        repeat (n) @(negedge clk);
    endtask

    // Ideal cycles of bit i of a frame at rate b (boundaries at round-down of i*F/b).
    function automatic longint bit_len(input int i, input longint b);
        return ((i + 1) * longint'(CLKF)) / b - (i * longint'(CLKF)) / b;
    endfunction

    // Drive one 8N1 frame on rx; abort_bit >= 0 returns halfway through that frame bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int abort_bit);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            if (i == abort_bit) begin
                wait_cyc(bit_len(i, baud) / 2);
                return;
            end
            wait_cyc(bit_len(i, baud));
        end
        rx = 1'b1;
    endtask

    // Write a byte and check the line at each ideal bit centre and the busy length.
    task automatic tx_check(input logic [7:0] d, input string nm);
        logic [9:0] f;
        int t, ctr, per, lim;
        f   = {1'b1, d, 1'b0};
        per = CLKF / int'(baud);
        lim = 11 * per;
        tx_data = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        t = 0;
        chk({nm, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < 10; i++) begin
            ctr = int'(((2 * i + 1) * longint'(CLKF)) / (2 * longint'(baud)));
            while (t < ctr) begin @(negedge clk); t++; end
            chk($sformatf("%s_bit%0d", nm, i), 32'(tx), 32'(f[i]));
        end
        while (busy && t < lim) begin @(negedge clk); t++; end
        chk_rng({nm, "_busy_len"}, t, 10 * CLKF / int'(baud) - 2, 10 * CLKF / int'(baud) + 2);
    endtask

    // Standalone tick generator at 115200 Hz.
    initial begin
        int t, last, nt;
        g_resetq = 1'b0; g_restart = 1'b0;
        repeat (2) @(negedge clk);
        g_resetq = 1'b1; g_restart = 1'b1;
        @(negedge clk);
        g_restart = 1'b0;
        t = 0; last = 0; nt = 0;
        while (nt < 20 && t < 20000) begin
            if (g_tick) begin
                chk_rng($sformatf("tick_spacing%0d", nt), t - last, CLKF / SLOW, CLKF / SLOW + 1);
                last = t;
                nt++;
            end
            @(negedge clk);
            t++;
        end
        chk("tick_count", 32'(nt), 32'd20);
        chk_rng("tick_total20", last, int'(20 * longint'(CLKF) / SLOW) - 1, int'(20 * longint'(CLKF) / SLOW) + 1);
        tick_done = 1'b1;
    end

    initial begin
        int t, last_t, nseg, saw;
        logic prev;
        logic [7:0] b;
        logic model_v;
        logic [7:0] model_d;

        tbl[0] = '{8'hAA, 1'b1, 1'b1, 1'b1, 8'hAA};
        tbl[1] = '{8'hBB, 1'b1, 1'b1, 1'b1, 8'hBB};
        tbl[2] = '{8'h12, 1'b1, 1'b0, 1'b1, 8'h12};
        tbl[3] = '{8'h34, 1'b1, 1'b0, 1'b1, 8'h34};   // overrun keeps valid
        tbl[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00};
        tbl[5] = '{8'hFF, 1'b0, 1'b0, FR_V, FR_D};     // stop bit forced low
        tbl[6] = '{8'h81, 1'b1, 1'b1, 1'b1, 8'h81};

        resetq = 1'b0; rx = 1'b1; rd = 1'b0; wr = 1'b0; tx_data = 8'h00; baud = 32'(SLOW);
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        resetq = 1'b1;
        @(negedge clk);

        // ---- transmit 0x55 at 115200, with an ignored write while busy ----
        tx_data = 8'h55; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0; tx_data = 8'h00;
        chk("tx55_start_tx", 32'(tx), 32'd0);
        chk("tx55_start_busy", 32'(busy), 32'd1);
        t = 0; last_t = 0; nseg = 0; prev = 1'b0;
        while (busy && t < 12 * 869) begin
            @(negedge clk);
            t++;
            if (busy && tx != prev) begin
                chk_rng($sformatf("tx55_seg%0d", nseg), t - last_t, 868, 869);
                nseg++; last_t = t; prev = tx;
            end
            if (t == 3000) wr = 1'b1;
            if (t == 3001) wr = 1'b0;
        end
        chk("tx55_segments", 32'(nseg), 32'd9);
        chk_rng("tx55_stop_len", t - last_t, 868, 869);
        chk_rng("tx55_busy_len", t, 8679, 8683);
        // accepted on the very cycle busy is seen low
        tx_data = 8'hA5; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        chk("tx_b2b_tx", 32'(tx), 32'd0);
        chk("tx_b2b_busy", 32'(busy), 32'd1);
        t = 0;
        while (busy && t < 10000) begin @(negedge clk); t++; end
        chk("tx_b2b_done", 32'(busy), 32'd0);

        baud = 32'(FAST);
        wait_cyc(4);

        // ---- table-driven receive ----
        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i].d, tbl[i].stop, -1);
            chk($sformatf("rx%0d_valid", i), 32'(valid), 32'(tbl[i].exp_v));
            chk($sformatf("rx%0d_data", i), 32'(rx_data), 32'(tbl[i].exp_d));
            if (tbl[i].rd) begin
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
                chk($sformatf("rx%0d_rd_clear", i), 32'(valid), 32'd0);
            end
            if (!tbl[i].stop) wait_cyc(bit_len(0, baud));
        end

        // ---- rd held high across a byte load: load wins for one cycle ----
        rd = 1'b1; saw = 0;
        fork
            send_frame(8'h6E, 1'b1, -1);
            begin
                repeat (10 * CLKF / FAST) begin
                    @(negedge clk);
                    if (valid) saw++;
                end
            end
        join
        rd = 1'b0;
        chk("rdcoll_valid_cycles", 32'(saw), 32'd1);
        chk("rdcoll_data", 32'(rx_data), 32'h6E);

        // ---- glitch shorter than half a bit ----
        rx = 1'b0;
        wait_cyc(20);
        rx = 1'b1;
        wait_cyc(bit_len(0, baud));
        chk("glitch_valid", 32'(valid), 32'd0);
        send_frame(8'h3C, 1'b1, -1);
        chk("glitch_next_valid", 32'(valid), 32'd1);
        chk("glitch_next_data", 32'(rx_data), 32'h3C);

        // ---- random receive against a byte-level model ----
        model_v = 1'b1; model_d = 8'h3C;
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1, -1);
            model_v = 1'b1; model_d = b;
            chk($sformatf("rnd%0d_valid", k), 32'(valid), 32'(model_v));
            chk($sformatf("rnd%0d_data", k), 32'(rx_data), 32'(model_d));
            if ($urandom_range(0, 1) == 1) begin
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
                model_v = 1'b0;
                chk($sformatf("rnd%0d_rd", k), 32'(valid), 32'(model_v));
            end
            if ($urandom_range(0, 1) == 1) wait_cyc($urandom_range(1, 200));
        end

        // ---- random transmit ----
        for (int k = 0; k < 3; k++) tx_check(8'($urandom_range(0, 255)), $sformatf("txr%0d", k));

        // ---- reset during TX data bit 4 and RX data bit 3 ----
        send_frame(8'h77, 1'b1, -1);
        chk("pre_rst_valid", 32'(valid), 32'd1);
        tx_data = 8'hC3; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        wait_cyc(bit_len(0, baud));
        send_frame(8'hE1, 1'b1, 4);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        resetq = 1'b0; rx = 1'b1;
        @(negedge clk);
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_rx_data", 32'(rx_data), 32'd0);
        resetq = 1'b1;
        wait_cyc(2 * bit_len(0, baud));
        send_frame(8'h5A, 1'b1, -1);
        chk("post_rst_valid", 32'(valid), 32'd1);
        chk("post_rst_data", 32'(rx_data), 32'h5A);
        tx_check(8'h96, "tx_post_rst");

        for (int i = 0; i < 30000 && !tick_done; i++) @(negedge clk);
        chk("tick_test_done", 32'(tick_done), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
